// File: rtl/elevator_scheduler_pkg.sv
// elev_pkg: floor codes, FSM states and SCAN target selection for elevator_scheduler.
package elev_pkg;
    localparam logic [2:0] FLOOR_A = 3'b001;
    localparam logic [2:0] FLOOR_B = 3'b010;
    localparam logic [2:0] FLOOR_C = 3'b011;
    localparam logic [2:0] FLOOR_D = 3'b100;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] floor;
    } hit_t;

    typedef struct packed {
        logic       dir_up;
        logic [2:0] floor;
    } tgt_t;

    function automatic logic [1:0] floor_to_idx(input logic [2:0] f);
        return 2'(f - 3'd1);
    endfunction

    function automatic logic [2:0] idx_to_floor(input logic [1:0] i);
        return i == 2'd0 ? FLOOR_A : i == 2'd1 ? FLOOR_B : i == 2'd2 ? FLOOR_C : FLOOR_D;
    endfunction

    // Nearest pending floor strictly ahead of cur; the last match in scan order is the nearest.
    function automatic hit_t scan_dir(input logic [3:0] p, input logic [2:0] cur, input logic up);
        hit_t       r;
        logic [1:0] c;
        logic [1:0] i;
        r.hit   = 1'b0;
        r.floor = cur;
        c       = floor_to_idx(cur);
        for (int k = 0; k < 4; k++) begin
            i = up ? 2'(3 - k) : 2'(k);
            if (p[i] && (up ? i > c : i < c)) begin
                r.hit   = 1'b1;
                r.floor = idx_to_floor(i);
            end
        end
        return r;
    endfunction

    function automatic tgt_t next_target(input logic [3:0] p, input logic [2:0] cur, input logic up);
        hit_t a;
        hit_t b;
        tgt_t r;
        a        = scan_dir(p, cur, up);
        b        = scan_dir(p, cur, !up);
        r.dir_up = a.hit ? up : b.hit ? !up : up;
        r.floor  = a.hit ? a.floor : b.hit ? b.floor : cur;
        return r;
    endfunction
endpackage

// File: rtl/elevator_scheduler_if.sv
// elevator_scheduler_if: call inputs and status outputs of the scheduler.
// door_hold exists only when ELEV_DOOR_HOLD_EN is defined.
interface elevator_scheduler_if;
    logic [3:0] call_req;
    logic [2:0] target_floor;
    logic [2:0] cur_floor;
    logic [3:0] pending;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic       busy;
`ifdef ELEV_DOOR_HOLD_EN
    logic       door_hold;
`endif

    modport slave (
`ifdef ELEV_DOOR_HOLD_EN
        input  door_hold,
`endif
        input  call_req,
        output target_floor, cur_floor, pending, dir_up, moving, door_open, busy
    );

    modport master (
`ifdef ELEV_DOOR_HOLD_EN
        output door_hold,
`endif
        output call_req,
        input  target_floor, cur_floor, pending, dir_up, moving, door_open, busy
    );
endinterface

// File: rtl/elevator_scheduler_dwell_timer.sv
// elev_dwell_timer: shared count-down timer pacing floor travel and door dwell.
module elev_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_,
    input  logic         load_i,
    input  logic         hold_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (!hold_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    // Fires in the cycle whose decrement reaches zero, so a load of N yields N cycles.
    assign expire_o = !hold_i && cnt_q == W'(1);
endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: latches floor calls and steps the car with a collective SCAN policy.
// Define ELEV_DOOR_HOLD_EN to add door_hold, which freezes the door dwell timer.
module elevator_scheduler
    import elev_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input logic                  clk,
    input logic                  clr_,
    elevator_scheduler_if.slave  bus
);
    localparam int MAXC = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    state_t        state_q, state_d;
    logic [2:0]    cur_q, cur_d, tgt_q, tgt_d, step;
    logic [3:0]    pend_q, pend_d, cur_oh;
    logic          dir_q, dir_d, moving_q, door_q, busy_q;
    logic          load, hold, expire, same_call, entry;
    logic [TW-1:0] load_val;
    tgt_t          t_idle;
    hit_t          t_move;

    elev_dwell_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .clr_       (clr_),
        .load_i     (load),
        .hold_i     (hold),
        .load_val_i (load_val),
        .expire_o   (expire)
    );

    always_comb begin
        t_idle    = next_target(pend_q, cur_q, dir_q);
        t_move    = scan_dir(pend_q, cur_q, dir_q);
        step      = dir_q ? cur_q + 3'd1 : cur_q - 3'd1;
        cur_oh    = 4'b0001 << floor_to_idx(cur_q);
        same_call = state_q == DOOR && |(bus.call_req & cur_oh);
`ifdef ELEV_DOOR_HOLD_EN
        hold      = state_q == IDLE || (state_q == DOOR && bus.door_hold);
`else
        hold      = state_q == IDLE;
`endif
        state_d   = state_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        dir_d     = dir_q;
        if (state_q == IDLE && |pend_q) begin
            tgt_d   = t_idle.floor;
            dir_d   = t_idle.dir_up;
            state_d = t_idle.floor == cur_q ? DOOR : MOVE;
        end
        // While moving, only calls ahead retarget; direction is frozen until IDLE.
        if (state_q == MOVE) begin
            tgt_d = t_move.hit ? t_move.floor : tgt_q;
            if (expire) begin
                cur_d   = step;
                state_d = pend_q[floor_to_idx(step)] ? DOOR : MOVE;
            end
        end
        if (state_q == DOOR && expire && !same_call) state_d = IDLE;
        entry    = state_d == DOOR && state_q != DOOR;
        pend_d   = (pend_q & ~(entry ? 4'b0001 << floor_to_idx(cur_d) : 4'b0000))
                 | (bus.call_req & ~(state_q == DOOR ? cur_oh : 4'b0000));
        load     = (state_d == MOVE && (state_q != MOVE || expire)) || entry || same_call;
        load_val = state_d == MOVE ? TW'(TRAVEL_CYCLES) : TW'(DOOR_CYCLES);
    end

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            state_q  <= IDLE;
            cur_q    <= FLOOR_A;
            tgt_q    <= FLOOR_A;
            pend_q   <= '0;
            dir_q    <= 1'b1;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            tgt_q    <= tgt_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            moving_q <= state_d == MOVE;
            door_q   <= state_d == DOOR;
            busy_q   <= state_d != IDLE || |pend_d;
        end
    end

    assign bus.target_floor = tgt_q;
    assign bus.cur_floor    = cur_q;
    assign bus.pending      = pend_q;
    assign bus.dir_up       = dir_q;
    assign bus.moving       = moving_q;
    assign bus.door_open    = door_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed scenarios plus random calls, checked every cycle against
// a floor-index model of the SCAN scheduler.
module tb_elevator_scheduler;
    localparam int T = 4;
    localparam int D = 8;
    localparam logic [13:0] RST_V = {3'b001, 3'b001, 4'b0000, 4'b1000};

    logic clk;
    logic clr_;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    elevator_scheduler_if bus ();
    elevator_scheduler #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (.clk(clk), .clr_(clr_), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 travelling, 2 door open; floors as indices 0..3.
    int       m_mode, m_left, m_cur, m_tgt;
    bit       m_up;
    bit [3:0] m_pend;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_cur = 0; m_tgt = 0; m_up = 1'b1; m_pend = '0;
    endtask

    task automatic model_step(input logic [3:0] c, input logic h);
        bit [3:0] np;
        int above, below, oc, om;
        np = m_pend; oc = m_cur; om = m_mode; above = -1; below = -1;
        for (int i = 3; i > m_cur; i--) if (m_pend[i]) above = i;
        for (int i = 0; i < m_cur; i++) if (m_pend[i]) below = i;
        if (m_mode == 0) begin
            if (m_pend != 0) begin
                if (m_up && above < 0 && below >= 0) m_up = 1'b0;
                else if (!m_up && below < 0 && above >= 0) m_up = 1'b1;
                m_tgt = m_up ? (above >= 0 ? above : m_cur) : (below >= 0 ? below : m_cur);
                if (m_tgt == m_cur) begin m_mode = 2; m_left = D; np[m_cur] = 1'b0; end
                else begin m_mode = 1; m_left = T; end
            end
        end else if (m_mode == 1) begin
            if (m_up && above >= 0) m_tgt = above;
            if (!m_up && below >= 0) m_tgt = below;
            m_left--;
            if (m_left == 0) begin
                m_cur = m_up ? m_cur + 1 : m_cur - 1;
                if (m_pend[m_cur]) begin m_mode = 2; m_left = D; np[m_cur] = 1'b0; end
                else m_left = T;
            end
        end else begin
            if (c[m_cur]) m_left = D;
            else if (!h) begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
        for (int i = 0; i < 4; i++) if (c[i] && !(om == 2 && i == oc)) np[i] = 1'b1;
        m_pend = np;
    endtask

    function automatic logic [13:0] model_v();
        return {3'(m_tgt + 1), 3'(m_cur + 1), m_pend, m_up, m_mode == 1, m_mode == 2,
                m_mode != 0 || m_pend != 0};
    endfunction

    function automatic logic [13:0] dut_v();
        return {bus.target_floor, bus.cur_floor, bus.pending, bus.dir_up, bus.moving,
                bus.door_open, bus.busy};
    endfunction

    logic hold_v;
`ifdef ELEV_DOOR_HOLD_EN
    assign hold_v = bus.door_hold;
`else
    assign hold_v = 1'b0;
`endif

    always @(posedge clk) begin
        if (!clr_) model_reset();
        else model_step(bus.call_req, hold_v);
    end

    always @(negedge clk) begin
        cycle++;
        if (clr_) begin
            checks++;
            if (dut_v() !== model_v()) begin
                errors++;
                $display("FAIL model cycle %0d dut tgt/cur/pend/dir/mov/door/busy=%b expected=%b",
                         cycle, dut_v(), model_v());
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] c);
        bus.call_req = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr_ = 1'b0;
        bus.call_req = '0;
        @(negedge clk);
        @(negedge clk);
        clr_ = 1'b1;
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        while (bus.busy && n < maxc) begin cyc(4'b0000); n++; end
        chk("settle_busy", int'(bus.busy), 0);
    endtask

    int stops[4];
    int dirs[4];
    int ns;

    task automatic collect(input int maxc);
        int  n = 0;
        logic prev;
        ns = 0;
        prev = bus.door_open;
        while (bus.busy && n < maxc) begin
            cyc(4'b0000);
            n++;
            if (bus.door_open && !prev && ns < 4) begin
                stops[ns] = int'(bus.cur_floor);
                dirs[ns]  = int'(bus.dir_up);
                ns++;
            end
            prev = bus.door_open;
        end
        chk("collect_settle", int'(bus.busy), 0);
    endtask

    initial begin
        int n, nc, mv;
        int ch[3];
        int cv[3];
        logic [2:0] prev;
        clr_ = 1'b0;
        bus.call_req = '0;
`ifdef ELEV_DOOR_HOLD_EN
        bus.door_hold = 1'b0;
`endif
        do_reset();
        chk("reset_outputs", int'(dut_v()), int'(RST_V));

        // Call at the current floor
        cyc(4'b0001);
        chk("same_floor_pending", int'(bus.pending), 1);
        chk("same_floor_door_early", int'(bus.door_open), 0);
        cyc(4'b0000);
        chk("same_floor_door_cycle2", int'(bus.door_open), 1);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            cyc(4'b0000);
            if (!bus.door_open) break;
            n++;
        end
        chk("door_cycles", n, D);
        chk("door_pending_clear", int'(bus.pending), 0);
        chk("door_cur_a", int'(bus.cur_floor), 1);
        run_idle(50);

        // A to D travel pacing
        do_reset();
        cyc(4'b1000);
        nc = 0;
        prev = bus.cur_floor;
        for (int j = 1; j <= 20; j++) begin
            cyc(4'b0000);
            if (j == 1) chk("ad_target", int'(bus.target_floor), 4);
            if (bus.cur_floor != prev && nc < 3) begin
                ch[nc] = j; cv[nc] = int'(bus.cur_floor); nc++;
            end
            prev = bus.cur_floor;
            if (j == 13) chk("ad_door_at_d", int'(bus.door_open), 1);
        end
        chk("ad_steps", nc, 3);
        chk("ad_step1_cycle", ch[0], 5);
        chk("ad_step2_cycle", ch[1], 9);
        chk("ad_step3_cycle", ch[2], 13);
        chk("ad_step1_floor", cv[0], 2);
        chk("ad_step2_floor", cv[1], 3);
        chk("ad_step3_floor", cv[2], 4);
        run_idle(100);

        // Intermediate call ahead of the moving car
        do_reset();
        cyc(4'b1000);
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b0100);
        collect(200);
        chk("mid_nstops", ns, 2);
        chk("mid_stop0", stops[0], 3);
        chk("mid_stop1", stops[1], 4);

        // At C going up, calls at A and D together
        do_reset();
        cyc(4'b0100);
        run_idle(100);
        chk("scan_at_c", int'(bus.cur_floor), 3);
        chk("scan_dir_up", int'(bus.dir_up), 1);
        cyc(4'b1001);
        collect(300);
        chk("scan_nstops", ns, 2);
        chk("scan_stop0", stops[0], 4);
        chk("scan_stop1", stops[1], 1);
        chk("scan_dir_at_a", dirs[1], 0);

        // Asynchronous reset mid-travel
        do_reset();
        cyc(4'b1000);
        cyc(4'b0000);
        cyc(4'b0010);
        chk("rst_pending_before", int'(bus.pending), 4'b1010);
        chk("rst_moving_before", int'(bus.moving), 1);
        #3 clr_ = 1'b0;
        #1 chk("rst_async_outputs", int'(dut_v()), int'(RST_V));
        @(negedge clk);
        @(negedge clk);
        clr_ = 1'b1;
        mv = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(4'b0000);
            if (bus.moving || bus.cur_floor != 3'b001) mv++;
        end
        chk("rst_no_motion", mv, 0);

`ifdef ELEV_DOOR_HOLD_EN
        do_reset();
        cyc(4'b0001);
        cyc(4'b0000);
        n = int'(bus.door_open);
        bus.door_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin cyc(4'b0000); n += int'(bus.door_open); end
        bus.door_hold = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc(4'b0000);
            if (!bus.door_open) break;
            n++;
        end
        chk("hold_door_cycles", n, D + 5);
        run_idle(50);
`endif

        // Random calls
        do_reset();
        for (int k = 0; k < 3000; k++) begin
`ifdef ELEV_DOOR_HOLD_EN
            bus.door_hold = $urandom_range(0, 3) == 0;
`endif
            cyc($urandom_range(0, 5) == 0 ? 4'($urandom) : 4'b0000);
        end
`ifdef ELEV_DOOR_HOLD_EN
        bus.door_hold = 1'b0;
`endif
        run_idle(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler for the 4-floor elevator. It latches floor calls and selects the next target floor using a collective SCAN policy (keep direction while calls remain ahead). It paces floor-to-floor travel and door dwell with one timer. Its `target_floor` output drives the `w` input of the floor state machine, and `cur_floor` tracks that machine's state.

## Interface
- `TRAVEL_CYCLES`, default 4: clock cycles to move one floor; legal range ≥1.
- `DOOR_CYCLES`, default 8: clock cycles the door stays open per stop; legal range ≥1.
- `clk`, input, 1: clock, rising edge.
- `clr_`, input, 1: reset, asynchronous, active-low.
- `call_req`, input, 4: one-cycle call pulses; bit0 = ground floor (A), bit3 = floor 4 (D); multiple bits may be set.
- `target_floor`, output, 3: floor code sent to the floor FSM. Codes: A=3'b001, B=3'b010, C=3'b011, D=3'b100.
- `cur_floor`, output, 3: floor the car is at; same encoding.
- `pending`, output, 4: latched unserved calls; same bit order as `call_req`.
- `dir_up`, output, 1: current sweep direction; 1 = upward.
- `moving`, output, 1: high in MOVE.
- `door_open`, output, 1: high in DOOR.
- `busy`, output, 1: high when state ≠ IDLE or `pending` ≠ 0.
- `door_hold`, input, 1: present only with `ELEV_DOOR_HOLD_EN`.

## Operation
- Reset values:
  - state = IDLE
  - `cur_floor` = `target_floor` = 3'b001
  - `pending` = 0
  - `dir_up` = 1
  - `moving` = `door_open` = `busy` = 0
  - timer = 0
- Reset is honoured mid-MOVE or mid-DOOR: all requests are discarded and the car position returns to floor A.
- Request latch: `pending[i]` is set the cycle after `call_req[i]`.
  - A set and a clear of the same bit in the same cycle: set wins.
  - Exception: in DOOR, a call for `cur_floor` is never latched.
- IDLE:
  - `pending` == 0: stay in IDLE.
  - Otherwise choose the target with SCAN:
    - `dir_up`=1: nearest pending floor above `cur_floor`. If none, set `dir_up`=0 and take the nearest pending floor below.
    - `dir_up`=0: the mirror of the above.
    - If the only pending floor is `cur_floor`, the target is `cur_floor`.
  - Target == `cur_floor`: go to DOOR.
  - Otherwise go to MOVE and load the timer with `TRAVEL_CYCLES`.
- MOVE:
  - The timer decrements each cycle.
  - On expiry, `cur_floor` steps one floor toward `target_floor`.
  - If the new floor has `pending` set (including an intermediate floor), go to DOOR. Otherwise reload the timer and continue.
  - `target_floor` is re-evaluated each cycle with the SCAN rule in the current direction only, so a new call ahead of the car can retarget it closer.
  - Direction never reverses during MOVE.
- DOOR:
  - On entry, clear `pending[cur_floor]` and load the timer with `DOOR_CYCLES`.
  - A `call_req` for `cur_floor` while in DOOR reloads the timer (restarts dwell).
  - On expiry, go to IDLE.
- Floor ↔ index arithmetic: index = code − 1. Codes 3'b000 and 3'b101–3'b111 are never produced.
- Timer width is $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1) bits; the counter never wraps.

## Timing
- Call to `pending` visible: 1 cycle.
- IDLE decision: 1 cycle.
  - Call at the current floor while idle: call pulse at cycle 0 → `door_open` from cycle 2.
- Per floor: exactly `TRAVEL_CYCLES` cycles in MOVE before `cur_floor` changes.
- Door open for exactly `DOOR_CYCLES` cycles when not extended.
- After the door closes, at least one IDLE cycle occurs before the next MOVE.
- All outputs are registered; no combinational path from `call_req` to any output.

## Configuration
- `ELEV_DOOR_HOLD_EN` defined:
  - The `door_hold` port exists.
  - While `door_hold`=1 in DOOR, the timer holds and does not decrement.
  - `door_hold` is ignored outside DOOR.
- Undefined: there is no `door_hold` port, and dwell ends strictly after `DOOR_CYCLES` cycles (apart from same-floor call reloads).

## Structure
- Package `elev_pkg`:
  - floor code localparams `FLOOR_A`..`FLOOR_D`
  - state enum IDLE/MOVE/DOOR
  - functions `floor_to_idx` / `idx_to_floor`
  - SCAN helper `next_target(pending, cur, dir_up)`
- Sub-module `elev_dwell_timer`: load value, load strobe, hold, count-down, and an `expire` pulse; shared between travel and door dwell.

## Test plan
- Reset, then `call_req`=4'b0001 at floor A → `door_open` for 8 cycles, `pending` returns to 0, `cur_floor` stays 3'b001.
- `call_req`=4'b1000 from A → `target_floor`=3'b100; `cur_floor` steps 010, 011, 100 at 4-cycle intervals; then `door_open`.
- Car moving A→D, `call_req`=4'b0100 while between A and B → stop at C first, then continue to D.
- Car at C with `dir_up`=1, calls at A and D together → D served first, then `dir_up`=0 and A served.
- `clr_` asserted mid-MOVE with pending 4'b1010 → all outputs reach reset values asynchronously; no motion after release.
- With `ELEV_DOOR_HOLD_EN`: `door_hold` held for 5 cycles in DOOR → door open for 13 cycles.
